pixel_stream_loader: RTL

PIXEL_STREAM_LOADER -- requirements
Module: pixel_stream_loader

---
 rtl/led_pkg.sv | 18 +
 rtl/idle_timer.sv | 33 +++
 rtl/pixel_stream_loader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// led_pkg: definitions shared by the pixel stream loader and the matrix driver.
//   channel_e   : colour channel the loader expects next (R, G, B byte order)
//   DEF_X_RES   : default pixels per row
//   DEF_Y_RES   : default rows per frame
//   DEF_TIMEOUT : default idle cycles before a resync (1 ms at 48 MHz)
package led_pkg;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } channel_e;

  localparam int unsigned DEF_X_RES   = 32;
  localparam int unsigned DEF_Y_RES   = 16;
  localparam int unsigned DEF_TIMEOUT = 48000;

endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts clock cycles since the last restart, saturating at TIMEOUT.
//   clk     : clock
//   reset_n : asynchronous active-low reset, clears the count
//   restart : clears the count (tie to the byte strobe)
//   expire  : high during the TIMEOUT-th idle cycle, once per idle gap
module idle_timer
  import led_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic expire
);

  localparam int unsigned   CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC    = CW'(TIMEOUT);
  localparam logic [CW-1:0] TC_M1 = CW'(TIMEOUT - 1);

  logic [CW-1:0] idle_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              idle_cnt <= '0;
    else if (restart)          idle_cnt <= '0;
    else if (idle_cnt != TC)   idle_cnt <= idle_cnt + 1'b1;
  end

  // Decoded from the count alone so a strobe arriving in the expiry cycle
  // still sees the resync; once saturated the count never matches again.
  assign expire = (idle_cnt == TC_M1);

endmodule

// File: rtl/pixel_stream_loader.sv
// pixel_stream_loader: assembles R,G,B byte triples from the UART into
// framebuffer writes, walking the pixel position in raster order.
//   clk, reset_n          : clock, asynchronous active-low reset
//   rx_data, rx_strobe    : received byte and its one-cycle valid pulse
//   wr_strobe             : one-cycle framebuffer write pulse
//   wr_x, wr_y            : write position
//   wr_r, wr_g, wr_b      : pixel colour, stable until the next write
//   frame_done, bank      : last-pixel pulse and display bank (toggles with it)
//   resync_err, err_count : timeout discarded a partial frame / saturating tally
//
// state | meaning
// CH_R  | next byte is red of the current pixel
// CH_G  | next byte is green
// CH_B  | next byte is blue; it completes the pixel and triggers the write
module pixel_stream_loader
  import led_pkg::*;
#(
  parameter int unsigned X_RES   = DEF_X_RES,
  parameter int unsigned Y_RES   = DEF_Y_RES,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic       wr_strobe,
  output logic [7:0] wr_x,
  output logic [7:0] wr_y,
  output logic [7:0] wr_r,
  output logic [7:0] wr_g,
  output logic [7:0] wr_b,
  output logic       frame_done,
  output logic       bank,
  output logic       resync_err,
  output logic [7:0] err_count
);

  localparam logic [7:0] X_LAST = 8'(X_RES - 1);
  localparam logic [7:0] Y_LAST = 8'(Y_RES - 1);

  channel_e   ch, ch_d, ch_eff;
  logic [7:0] pos_x, pos_y, pos_x_d, pos_y_d, x_eff, y_eff;
  logic [7:0] hold_r, hold_g, hold_r_d, hold_g_d;
  logic [7:0] wr_x_d, wr_y_d, wr_r_d, wr_g_d, wr_b_d, err_count_d;
  logic       wr_strobe_d, frame_done_d, bank_d, resync_err_d;
  logic       expire;

  idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (rx_strobe),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch         <= CH_R;
      pos_x      <= '0;
      pos_y      <= '0;
      hold_r     <= '0;
      hold_g     <= '0;
      wr_strobe  <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_r       <= '0;
      wr_g       <= '0;
      wr_b       <= '0;
      frame_done <= 1'b0;
      bank       <= 1'b0;
      resync_err <= 1'b0;
      err_count  <= '0;
    end else begin
      ch         <= ch_d;
      pos_x      <= pos_x_d;
      pos_y      <= pos_y_d;
      hold_r     <= hold_r_d;
      hold_g     <= hold_g_d;
      wr_strobe  <= wr_strobe_d;
      wr_x       <= wr_x_d;
      wr_y       <= wr_y_d;
      wr_r       <= wr_r_d;
      wr_g       <= wr_g_d;
      wr_b       <= wr_b_d;
      frame_done <= frame_done_d;
      bank       <= bank_d;
      resync_err <= resync_err_d;
      err_count  <= err_count_d;
    end
  end

  always_comb begin
    ch_d         = ch;
    pos_x_d      = pos_x;
    pos_y_d      = pos_y;
    hold_r_d     = hold_r;
    hold_g_d     = hold_g;
    wr_strobe_d  = 1'b0;
    wr_x_d       = wr_x;
    wr_y_d       = wr_y;
    wr_r_d       = wr_r;
    wr_g_d       = wr_g;
    wr_b_d       = wr_b;
    frame_done_d = 1'b0;
    bank_d       = bank;
    resync_err_d = 1'b0;
    err_count_d  = err_count;

    // Resync is resolved first; a byte in the same cycle then sees the
    // post-resync state and lands as red of pixel (0,0).
    ch_eff = ch;
    x_eff  = pos_x;
    y_eff  = pos_y;
    if (expire) begin
      if (ch != CH_R || pos_x != 8'd0 || pos_y != 8'd0) begin
        resync_err_d = 1'b1;
        if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
      end
      ch_eff = CH_R;
      x_eff  = '0;
      y_eff  = '0;
    end
    ch_d    = ch_eff;
    pos_x_d = x_eff;
    pos_y_d = y_eff;

    if (rx_strobe) begin
      unique case (ch_eff)
        CH_R: begin
          hold_r_d = rx_data;
          ch_d     = CH_G;
        end
        CH_G: begin
          hold_g_d = rx_data;
          ch_d     = CH_B;
        end
        CH_B: begin
          ch_d        = CH_R;
          wr_strobe_d = 1'b1;
          wr_x_d      = x_eff;
          wr_y_d      = y_eff;
          wr_r_d      = hold_r;
          wr_g_d      = hold_g;
          wr_b_d      = rx_data;
          if (x_eff == X_LAST) begin
            pos_x_d = '0;
            if (y_eff == Y_LAST) begin
              pos_y_d      = '0;
              frame_done_d = 1'b1;
              bank_d       = ~bank;
            end else begin
              pos_y_d = y_eff + 8'd1;
            end
          end else begin
            pos_x_d = x_eff + 8'd1;
          end
        end
        default: ch_d = CH_R;
      endcase
    end
  end

endmodule
